// File: rtl/instr_encoder_pkg.sv
// Shared definitions for the RV32I instruction encoder: format codes,
// the canonical NOP word and the signed-range helper for immediate checks.
package instr_encoder_pkg;

  // Instruction format tags carried on the fmt input; 6 and 7 are illegal
  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  // addi x0, x0, 0
  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

  // True when imm[31:lsb] are all equal, i.e. imm is a sign extension of imm[lsb:0]
  function automatic logic fits_signed(input logic [31:0] imm, input int unsigned lsb);
    logic signed [31:0] s;
    s = $signed(imm) >>> lsb;
    return (s == '0) || (s == '1);
  endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational field packer: format-tagged fields -> 32-bit RV32I word.
// Optional immediate range checking is enabled with macro IMM_RANGE_CHECK_EN;
// without it err is tied low and illegal formats still produce a NOP.
module instr_pack
  import instr_encoder_pkg::*;
(
  input  logic [2:0]  fmt,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [31:0] imm,
  output logic [31:0] instr,
  output logic        err
);

  // Scatter fields and immediate bits into the format's bit layout
  always_comb begin
    instr = INSTR_NOP;
    case (fmt)
      FMT_R:   instr = {funct7, rs2, rs1, funct3, rd, opcode};
      FMT_I:   instr = {imm[11:0], rs1, funct3, rd, opcode};
      FMT_S:   instr = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
      FMT_B:   instr = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
      FMT_U:   instr = {imm[31:12], rd, opcode};
      FMT_J:   instr = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
      default: instr = INSTR_NOP;
    endcase
  end

`ifdef IMM_RANGE_CHECK_EN
  // Flag immediates that cannot be represented exactly, and illegal formats
  always_comb begin
    err = 1'b0;
    case (fmt)
      FMT_R:        err = 1'b0;
      FMT_I, FMT_S: err = !fits_signed(imm, 11);
      FMT_B:        err = !fits_signed(imm, 12) || imm[0];
      FMT_J:        err = !fits_signed(imm, 20) || imm[0];
      FMT_U:        err = (imm[11:0] != '0);
      default:      err = 1'b1;
    endcase
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: rtl/instr_encoder.sv
// Two-stage pipelined RV32I encoder with valid/ready on both sides and a
// running byte address for the emitted words. Stage 1 holds raw fields,
// stage 2 holds the packed word. Macro IMM_RANGE_CHECK_EN enables err.
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int unsigned          ADDR_W    = 32,
  parameter logic [ADDR_W-1:0]    BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        fmt,
  input  logic [6:0]        opcode,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  input  logic [31:0]       imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       instr,
  output logic [ADDR_W-1:0] addr,
  output logic              err
);

  logic        s1_valid;
  logic [2:0]  s1_fmt;
  logic [6:0]  s1_opcode;
  logic [4:0]  s1_rd;
  logic [4:0]  s1_rs1;
  logic [4:0]  s1_rs2;
  logic [2:0]  s1_funct3;
  logic [6:0]  s1_funct7;
  logic [31:0] s1_imm;
  logic [31:0] pack_instr;
  logic        pack_err;
  logic        s2_rdy;

  assign s2_rdy   = !out_valid || out_ready;
  assign in_ready = (!s1_valid || s2_rdy) && !clr;

  instr_pack u_pack (
    .fmt    (s1_fmt),
    .opcode (s1_opcode),
    .rd     (s1_rd),
    .rs1    (s1_rs1),
    .rs2    (s1_rs2),
    .funct3 (s1_funct3),
    .funct7 (s1_funct7),
    .imm    (s1_imm),
    .instr  (pack_instr),
    .err    (pack_err)
  );

  // Pipeline registers, handshake bookkeeping and output address counter;
  // clr overrides every handshake but a word leaving that cycle is still consumed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_fmt    <= '0;
      s1_opcode <= '0;
      s1_rd     <= '0;
      s1_rs1    <= '0;
      s1_rs2    <= '0;
      s1_funct3 <= '0;
      s1_funct7 <= '0;
      s1_imm    <= '0;
      out_valid <= 1'b0;
      instr     <= '0;
      err       <= 1'b0;
      addr      <= BASE_ADDR;
    end else if (clr) begin
      s1_valid  <= 1'b0;
      out_valid <= 1'b0;
      addr      <= BASE_ADDR;
    end else begin
      if (s2_rdy) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          instr <= pack_instr;
          err   <= pack_err;
        end
      end
      if (in_ready) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_fmt    <= fmt;
          s1_opcode <= opcode;
          s1_rd     <= rd;
          s1_rs1    <= rs1;
          s1_rs2    <= rs2;
          s1_funct3 <= funct3;
          s1_funct7 <= funct7;
          s1_imm    <= imm;
        end
      end
      if (out_valid && out_ready) begin
        addr <= addr + ADDR_W'(4);
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed vectors with hand-derived
// expected words, a scoreboard queue filled on input handshakes and drained
// on output handshakes, plus backpressure, clear, reset and address-wrap steps.
module tb_instr_encoder;

  localparam logic [31:0] BASE = 32'hFFFF_FFF0;

  logic        clk = 1'b0;
  logic        rst_n, clr, in_valid, in_ready, out_valid, out_ready, err;
  logic [2:0]  fmt, funct3;
  logic [6:0]  opcode, funct7;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] imm, instr, addr;

  typedef struct {
    logic [2:0]  fmt;
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic [31:0] instr;
    logic        err;
  } vec_t;

  typedef struct {
    logic [31:0] instr;
    logic        err;
  } exp_t;

  vec_t        vecs [15];
  exp_t        sb [$];
  int          cur = 0;
  int          n_assert = 0;
  int          n_fail = 0;
  logic [31:0] exp_addr = BASE;
  logic [31:0] held_instr, held_addr;

  always #5 clk = ~clk;

  instr_encoder #(.ADDR_W(32), .BASE_ADDR(BASE)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .fmt       (fmt),
    .opcode    (opcode),
    .rd        (rd),
    .rs1       (rs1),
    .rs2       (rs2),
    .funct3    (funct3),
    .funct7    (funct7),
    .imm       (imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .instr     (instr),
    .addr      (addr),
    .err       (err)
  );

  function automatic logic exp_err(input logic e);
`ifdef IMM_RANGE_CHECK_EN
    return e;
`else
    return 1'b0 & e;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Scoreboard push on every accepted input
  always @(negedge clk) begin
    if (rst_n && in_valid && in_ready)
      sb.push_back('{vecs[cur].instr, exp_err(vecs[cur].err)});
  end

  // Scoreboard pop and compare on every output handshake
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      check("word_expected", {31'd0, sb.size() != 0}, 32'd1);
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        check("instr", instr, e.instr);
        check("err", {31'd0, err}, {31'd0, e.err});
        check("addr", addr, exp_addr);
        exp_addr = exp_addr + 32'd4;
      end
    end
  end

  task automatic set_fields(input int i);
    cur    = i;
    fmt    = vecs[i].fmt;
    opcode = vecs[i].op;
    rd     = vecs[i].rd;
    rs1    = vecs[i].rs1;
    rs2    = vecs[i].rs2;
    funct3 = vecs[i].f3;
    funct7 = vecs[i].f7;
    imm    = vecs[i].imm;
  endtask

  task automatic drive(input int i);
    logic ok;
    ok = 1'b0;
    set_fields(i);
    in_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    check("in_ready_timeout", {31'd0, ok}, 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int k = 0; k < 30 && sb.size() != 0; k++) begin
      @(posedge clk);
      #2;
    end
    check("drain_empty", sb.size(), 32'd0);
  endtask

  initial begin
    //          fmt   op     rd     rs1    rs2    f3    f7     imm            instr          err
    vecs[0]  = '{3'd1, 7'h13, 5'd1,  5'd0,  5'd0,  3'd0, 7'h00, 32'd5,         32'h0050_0093, 1'b0};
    vecs[1]  = '{3'd3, 7'h63, 5'd0,  5'd1,  5'd2,  3'd0, 7'h00, 32'hFFFF_FFF8, 32'hFE20_8CE3, 1'b0};
    vecs[2]  = '{3'd1, 7'h13, 5'd1,  5'd0,  5'd0,  3'd0, 7'h00, 32'd2048,      32'h8000_0093, 1'b1};
    vecs[3]  = '{3'd5, 7'h6F, 5'd0,  5'd0,  5'd0,  3'd0, 7'h00, 32'd3,         32'h0020_006F, 1'b1};
    vecs[4]  = '{3'd7, 7'h7F, 5'd31, 5'd31, 5'd31, 3'd7, 7'h7F, 32'hFFFF_FFFF, 32'h0000_0013, 1'b1};
    vecs[5]  = '{3'd0, 7'h33, 5'd3,  5'd1,  5'd2,  3'd0, 7'h00, 32'h0,         32'h0020_81B3, 1'b0};
    vecs[6]  = '{3'd0, 7'h33, 5'd3,  5'd1,  5'd2,  3'd0, 7'h20, 32'h0,         32'h4020_81B3, 1'b0};
    vecs[7]  = '{3'd2, 7'h23, 5'd0,  5'd2,  5'd3,  3'd2, 7'h00, 32'hFFFF_FFFC, 32'hFE31_2E23, 1'b0};
    vecs[8]  = '{3'd4, 7'h37, 5'd5,  5'd0,  5'd0,  3'd0, 7'h00, 32'h1234_5000, 32'h1234_52B7, 1'b0};
    vecs[9]  = '{3'd4, 7'h37, 5'd5,  5'd0,  5'd0,  3'd0, 7'h00, 32'h1234_5678, 32'h1234_52B7, 1'b1};
    vecs[10] = '{3'd1, 7'h13, 5'd1,  5'd0,  5'd0,  3'd0, 7'h00, 32'hFFFF_F800, 32'h8000_0093, 1'b0};
    vecs[11] = '{3'd1, 7'h13, 5'd1,  5'd0,  5'd0,  3'd0, 7'h00, 32'd2047,      32'h7FF0_0093, 1'b0};
    vecs[12] = '{3'd3, 7'h63, 5'd0,  5'd1,  5'd2,  3'd0, 7'h00, 32'd4096,      32'h8020_8063, 1'b1};
    vecs[13] = '{3'd6, 7'h33, 5'd1,  5'd2,  5'd3,  3'd0, 7'h00, 32'd0,         32'h0000_0013, 1'b1};
    vecs[14] = '{3'd5, 7'h6F, 5'd1,  5'd0,  5'd0,  3'd0, 7'h00, 32'hFFFF_FFFC, 32'hFFDF_F0EF, 1'b0};

    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    set_fields(0);

    // Reset state
    #12;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_instr", instr, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_addr", addr, BASE);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;

    // Full-throughput stream of every vector; addresses wrap past 0xFFFF_FFFC
    for (int i = 0; i < 15; i++) drive(i);
    in_valid = 1'b0;
    drain();

    // Backpressure: two words buffered, input stalls, outputs hold
    out_ready = 1'b0;
    set_fields(1); in_valid = 1'b1;
    @(posedge clk); #1;
    set_fields(7);
    @(posedge clk); #1;
    set_fields(8);
    held_instr = instr;
    held_addr  = addr;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("stall_in_ready", {31'd0, in_ready}, 32'd0);
      check("stall_out_valid", {31'd0, out_valid}, 32'd1);
      check("stall_instr", instr, held_instr);
      check("stall_addr", addr, held_addr);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    drive(8);
    drive(14);
    in_valid = 1'b0;
    drain();

    // Synchronous clear with a word on the output being consumed that cycle
    out_ready = 1'b0;
    drive(5);
    drive(6);
    in_valid = 1'b0;
    check("pre_clr_out_valid", {31'd0, out_valid}, 32'd1);
    clr = 1'b1; out_ready = 1'b1;
    set_fields(7); in_valid = 1'b1;
    @(negedge clk);
    check("clr_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    clr = 1'b0; in_valid = 1'b0;
    check("clr_out_valid", {31'd0, out_valid}, 32'd0);
    check("clr_addr", addr, BASE);
    sb.delete();
    exp_addr = BASE;
    @(negedge clk);
    check("clr_stays_empty", {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;
    drive(0);
    in_valid = 1'b0;
    drain();

    // Asynchronous reset mid-cycle with words in flight
    out_ready = 1'b0;
    drive(2);
    drive(3);
    in_valid = 1'b0;
    check("pre_rst_out_valid", {31'd0, out_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", {31'd0, out_valid}, 32'd0);
    check("arst_addr", addr, BASE);
    check("arst_instr", instr, 32'd0);
    sb.delete();
    exp_addr = BASE;
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("arst_no_stale", {31'd0, out_valid}, 32'd0);
    drive(1);
    in_valid = 1'b0;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
